// File: rtl/div_unit_if.sv
// Start/busy/valid handshake between the ALU (requester) and the multi-cycle divider.
interface div_unit_if #(parameter int WIDTH = 32);
    logic             i_start;
    logic [WIDTH-1:0] i_op_a;
    logic [WIDTH-1:0] i_op_b;
    logic [1:0]       i_div_op;
    logic             o_busy;
    logic             o_valid;
    logic [WIDTH-1:0] o_div_data;

    modport master (output i_start, i_op_a, i_op_b, i_div_op,
                    input  o_busy, o_valid, o_div_data);
    modport slave  (input  i_start, i_op_a, i_op_b, i_div_op,
                    output o_busy, o_valid, o_div_data);
endinterface

// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the loop.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    LAST = CW'(WIDTH);
    localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] rem, rem_n;
    logic [WIDTH-1:0] dvd, dvd_n;   // dividend shifts out MSB first, quotient shifts in
    logic [WIDTH-1:0] dvs, dvs_n;
    logic [1:0]       op, op_n;
    logic             sa, sa_n, sb, sb_n;
    logic [WIDTH-1:0] data, data_n;

    logic             in_signed, a_neg, b_neg;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign in_signed = ~bus.i_div_op[0];
    assign a_neg     = in_signed & bus.i_op_a[WIDTH-1];
    assign b_neg     = in_signed & bus.i_op_b[WIDTH-1];
    assign rem_sh    = {rem, dvd[WIDTH-1]};
    assign quo_fix   = (~op[0] & (sa ^ sb)) ? -dvd : dvd;
    assign rem_fix   = (~op[0] & sa) ? -rem : rem;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= '0;
            dvd   <= '0;
            dvs   <= '0;
            op    <= '0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            data  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            rem   <= rem_n;
            dvd   <= dvd_n;
            dvs   <= dvs_n;
            op    <= op_n;
            sa    <= sa_n;
            sb    <= sb_n;
            data  <= data_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rem_n   = rem;
        dvd_n   = dvd;
        dvs_n   = dvs;
        op_n    = op;
        sa_n    = sa;
        sb_n    = sb;
        data_n  = data;
        case (state)
            CALC: begin
                if (cnt == LAST) begin
                    // Extra cycle after the last iteration applies the sign fix-up.
                    data_n  = op[1] ? rem_fix : quo_fix;
                    state_n = DONE;
                end else begin
                    if (rem_sh >= {1'b0, dvs}) begin
                        rem_n = rem_sh[WIDTH-1:0] - dvs;
                        dvd_n = {dvd[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_n = rem_sh[WIDTH-1:0];
                        dvd_n = {dvd[WIDTH-2:0], 1'b0};
                    end
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                if (bus.i_start) begin
                    op_n  = bus.i_div_op;
                    sa_n  = a_neg;
                    sb_n  = b_neg;
                    dvd_n = a_neg ? -bus.i_op_a : bus.i_op_a;
                    dvs_n = b_neg ? -bus.i_op_b : bus.i_op_b;
                    rem_n = '0;
                    cnt_n = '0;
                    if (bus.i_op_b == '0) begin
                        data_n  = bus.i_div_op[1] ? bus.i_op_a : '1;
                        state_n = DONE;
                    end else if (in_signed && bus.i_op_a == MIN && bus.i_op_b == '1) begin
                        data_n  = bus.i_div_op[1] ? '0 : bus.i_op_a;
                        state_n = DONE;
                    end else begin
                        state_n = CALC;
                    end
                end
            end
        endcase
    end

    assign bus.o_busy     = (state == CALC);
    assign bus.o_valid    = (state == DONE);
    assign bus.o_div_data = data;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed table, handshake corner cases, reset abort, random ops.
module tb_div_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    div_unit_if #(.WIDTH(32)) ifc ();
    div_unit #(.WIDTH(32)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(ifc.slave));

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic in 64 bits plus the RV32M divide-by-zero rule.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        case (op)
            2'b00:   return 32'(sa / sb);
            2'b01:   return 32'(ua / ub);
            2'b10:   return 32'(sa % sb);
            default: return 32'(ua % ub);
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return 0;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 33;
    endfunction

    // lat = rising edges after the accepting edge until o_valid is visible
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] d, output int lat, output bit bs);
        @(negedge clk);
        ifc.i_div_op = op;
        ifc.i_op_a   = a;
        ifc.i_op_b   = b;
        ifc.i_start  = 1'b1;
        @(posedge clk);
        #1;
        ifc.i_start  = 1'b0;
        ifc.i_op_a   = $urandom;
        ifc.i_op_b   = $urandom;
        ifc.i_div_op = 2'($urandom);
        lat = 0;
        bs  = ifc.o_busy;
        while (!ifc.o_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            bs |= ifc.o_busy;
        end
        d = ifc.o_div_data;
    endtask

    initial begin
        vec_t        vt[$];
        logic [31:0] d, a, b;
        logic [1:0]  op;
        int          lat, vseen;
        bit          bs;

        ifc.i_start  = 1'b0;
        ifc.i_op_a   = '0;
        ifc.i_op_b   = '0;
        ifc.i_div_op = '0;

        vt.push_back('{"divu_100_7",   2'b01, 32'd100,       32'd7,         32'd14,        33});
        vt.push_back('{"remu_100_7",   2'b01 | 2'b10, 32'd100, 32'd7,       32'd2,         33});
        vt.push_back('{"div_m100_7",   2'b00, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 33});
        vt.push_back('{"rem_m100_7",   2'b10, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 33});
        vt.push_back('{"rem_100_m7",   2'b10, 32'd100,       32'hFFFF_FFF9, 32'd2,         33});
        vt.push_back('{"div_by0",      2'b00, 32'h1234,      32'd0,         32'hFFFF_FFFF, 0});
        vt.push_back('{"divu_by0",     2'b01, 32'h1234,      32'd0,         32'hFFFF_FFFF, 0});
        vt.push_back('{"rem_by0",      2'b10, 32'h1234,      32'd0,         32'h1234,      0});
        vt.push_back('{"remu_by0",     2'b11, 32'h1234,      32'd0,         32'h1234,      0});
        vt.push_back('{"div_ovf",      2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0});
        vt.push_back('{"rem_ovf",      2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0});
        vt.push_back('{"divu_ovfops",  2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33});
        vt.push_back('{"remu_ovfops",  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33});

        // Reset state
        #12;
        chk("rst_busy",  {31'd0, ifc.o_busy},  32'd0);
        chk("rst_valid", {31'd0, ifc.o_valid}, 32'd0);
        chk("rst_data",  ifc.o_div_data,       32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        foreach (vt[i]) begin
            do_op(vt[i].op, vt[i].a, vt[i].b, d, lat, bs);
            chk({vt[i].name, "_data"}, d, vt[i].exp);
            chk({vt[i].name, "_lat"}, 32'(lat), 32'(vt[i].lat));
            chk({vt[i].name, "_busy"}, {31'd0, bs}, {31'd0, vt[i].lat != 0});
        end

        // Start while busy is dropped; start in the valid cycle is taken back-to-back
        @(negedge clk);
        ifc.i_div_op = 2'b01; ifc.i_op_a = 32'd1000; ifc.i_op_b = 32'd10; ifc.i_start = 1'b1;
        @(posedge clk);
        #1 ifc.i_start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        ifc.i_div_op = 2'b11; ifc.i_op_a = 32'd5; ifc.i_op_b = 32'd1; ifc.i_start = 1'b1;
        @(posedge clk);
        #1 ifc.i_start = 1'b0;
        lat = 10;
        while (!ifc.o_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("busy_ignore_lat",  32'(lat), 32'd33);
        chk("busy_ignore_data", ifc.o_div_data, 32'd100);
        do_op(2'b00, 32'hFFFF_FFCE, 32'd5, d, lat, bs);
        chk("b2b_lat",  32'(lat), 32'd33);
        chk("b2b_data", d, 32'hFFFF_FFF6);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_data",  ifc.o_div_data,       32'hFFFF_FFF6);
        chk("hold_valid", {31'd0, ifc.o_valid}, 32'd0);

        // Reset in the middle of CALC
        @(negedge clk);
        ifc.i_div_op = 2'b01; ifc.i_op_a = 32'd12345; ifc.i_op_b = 32'd3; ifc.i_start = 1'b1;
        @(posedge clk);
        #1 ifc.i_start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy",  {31'd0, ifc.o_busy},  32'd0);
        chk("midrst_valid", {31'd0, ifc.o_valid}, 32'd0);
        chk("midrst_data",  ifc.o_div_data,       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        vseen = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (ifc.o_valid) vseen++;
        end
        chk("midrst_no_valid", 32'(vseen), 32'd0);

        // Random operations against the reference
        for (int n = 0; n < 1500; n++) begin
            op = 2'($urandom);
            a  = $urandom;
            b  = $urandom >> $urandom_range(0, 31);
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                3: b = 32'hFFFF_FFFF - $urandom_range(0, 5);
                default: ;
            endcase
            do_op(op, a, b, d, lat, bs);
            chk($sformatf("rand%0d_op%0d_a%h_b%h", n, op, a, b), d, model(op, a, b));
            chk($sformatf("rand%0d_lat", n), 32'(lat), 32'(model_lat(op, a, b)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
